// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Instruction fetch / decode / branch sequencer. It fetches an instruction at
//   pc, decodes it for one cycle, and then does one of four things:
//   - resolves branches and register jumps itself;
//   - hands ALU and memory ops to an external execute FSM, and serves that
//     FSM's data accesses;
//   - stops in HALT on opcode 111;
//   - stops in HALT on undefined encodings, and sets the sticky illegal flag.
//
// Ports
//   clk, reset        rising-edge clock; asynchronous active-low reset
//   mem_rdata/ready   memory read data / access-complete strobe
//   mem_cmd/addr      memory command (00 none, 01 read, 10 write) and address
//   ir, pc            instruction register and program counter
//   N, V, Z           datapath status flags used by conditional branches
//   reg_value         Rd value, used as the target of BX / BLX
//   ex_start          one-cycle launch pulse to the execute FSM
//   ex_mem_req/wr/addr  data access request from the execute FSM
//   mem_ack           one-cycle pulse when that data access completes
//   ex_done           execute FSM has finished the instruction
//   link_we/link_pc   R7 write strobe and value (return address)
//   halted, illegal   sequencer stopped / undefined opcode seen (sticky)
module pc_sequencer #(
  parameter int ADDR_W   = 9,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [1:0]         mem_cmd,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  pc,
  input  logic               N,
  input  logic               V,
  input  logic               Z,
  input  logic [ADDR_W-1:0]  reg_value,
  output logic               ex_start,
  input  logic               ex_mem_req,
  input  logic               ex_wr,
  input  logic [ADDR_W-1:0]  ex_addr,
  output logic               mem_ack,
  input  logic               ex_done,
  output logic               link_we,
  output logic [ADDR_W-1:0]  link_pc,
  output logic               halted,
  output logic               illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_DMEM   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  daddr_q, daddr_d;
  logic               wr_q, wr_d;
  logic               illegal_q, illegal_d;

  // Instruction fields
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] cond;
  logic [7:0] imm8;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign cond   = ir_q[10:8];
  assign imm8   = ir_q[7:0];

  // Branch arithmetic wraps silently at 2^ADDR_W
  logic [ADDR_W-1:0] imm_sx, seq_pc, target_pc;

  assign imm_sx    = ADDR_W'($signed(imm8));
  assign seq_pc    = pc_q + ADDR_W'(1);
  assign target_pc = seq_pc + imm_sx;

  logic branch_taken;
  logic cond_valid;
  logic bad_instr;

  always_comb begin
    branch_taken = 1'b0;
    case (cond)
      3'd0:    branch_taken = 1'b1;            // B
      3'd1:    branch_taken = Z;               // BEQ
      3'd2:    branch_taken = !Z;              // BNE
      3'd3:    branch_taken = N ^ V;           // BLT
      3'd4:    branch_taken = (N ^ V) | Z;     // BLE
      default: branch_taken = 1'b0;
    endcase
  end

  assign cond_valid = (cond <= 3'd4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    daddr_d   = daddr_q;
    wr_d      = wr_q;
    illegal_d = illegal_q;
    mem_cmd   = CMD_NONE;
    mem_addr  = pc_q;
    ex_start  = 1'b0;
    mem_ack   = 1'b0;
    link_we   = 1'b0;
    halted    = 1'b0;
    bad_instr = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_cmd = CMD_READ;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_FETCH;
        case (opcode)
          3'b001: begin
            if (cond_valid) pc_d = branch_taken ? target_pc : seq_pc;
            else            bad_instr = 1'b1;
          end
          3'b010: begin
            case (op)
              2'b11: begin                      // BL
                link_we = 1'b1;
                pc_d    = target_pc;
              end
              2'b00: pc_d = reg_value;          // BX
              2'b10: begin                      // BLX
                link_we = 1'b1;
                pc_d    = reg_value;
              end
              default: bad_instr = 1'b1;
            endcase
          end
          3'b011, 3'b100, 3'b101, 3'b110: begin
            ex_start = 1'b1;
            state_d  = S_EXEC;
          end
          3'b111:  state_d = S_HALT;
          default: bad_instr = 1'b1;
        endcase
        if (bad_instr) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end

      S_EXEC: begin
        // A data request takes priority over a simultaneous done
        if (ex_mem_req) begin
          daddr_d = ex_addr;
          wr_d    = ex_wr;
          state_d = S_DMEM;
        end else if (ex_done) begin
          pc_d    = seq_pc;
          state_d = S_FETCH;
        end
      end

      S_DMEM: begin
        mem_cmd  = wr_q ? CMD_WRITE : CMD_READ;
        mem_addr = daddr_q;
        if (mem_ready) begin
          mem_ack = 1'b1;
          state_d = S_EXEC;
        end
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= ADDR_W'(RESET_PC);
      ir_q      <= '0;
      daddr_q   <= '0;
      wr_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      daddr_q   <= daddr_d;
      wr_q      <= wr_d;
      illegal_q <= illegal_d;
    end
  end

  assign ir      = ir_q;
  assign pc      = pc_q;
  assign link_pc = seq_pc;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer. The bench plays the memory and the
//   execute FSM. Expected program-counter flow comes from a behavioural model
//   of the instruction set, written with integer arithmetic.
//   Inputs are driven on the falling edge. Outputs are sampled 1 ns later.
module tb_pc_sequencer;
  localparam int ADDR_W   = 9;
  localparam int INSTR_W  = 16;
  localparam int RESET_PC = 0;
  localparam int AMASK    = (1 << ADDR_W) - 1;

  logic               clk;
  logic               reset;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_ready;
  logic [1:0]         mem_cmd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  pc;
  logic               N, V, Z;
  logic [ADDR_W-1:0]  reg_value;
  logic               ex_start;
  logic               ex_mem_req;
  logic               ex_wr;
  logic [ADDR_W-1:0]  ex_addr;
  logic               mem_ack;
  logic               ex_done;
  logic               link_we;
  logic [ADDR_W-1:0]  link_pc;
  logic               halted;
  logic               illegal;

  pc_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .ir(ir), .pc(pc),
    .N(N), .V(V), .Z(Z), .reg_value(reg_value), .ex_start(ex_start),
    .ex_mem_req(ex_mem_req), .ex_wr(ex_wr), .ex_addr(ex_addr), .mem_ack(mem_ack),
    .ex_done(ex_done), .link_we(link_we), .link_pc(link_pc), .halted(halted),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_pc;

  // Observations captured by the driver tasks
  int                 fetch_bad;
  logic [INSTR_W-1:0] o_ir;
  logic               o_ex_start, o_link_we;
  logic [ADDR_W-1:0]  o_link_pc, o_dec_pc;
  logic [1:0]         o_dec_cmd;
  logic [ADDR_W-1:0]  o_post_pc;
  logic [1:0]         o_post_cmd;
  logic               o_post_ex_start, o_post_halted, o_post_illegal;
  logic [ADDR_W-1:0]  o_fin_pre_pc, o_fin_pc;
  logic [1:0]         o_fin_cmd;

  function automatic logic [15:0] mk(input logic [2:0] opc, input logic [1:0] op,
                                     input logic [2:0] cnd, input logic [7:0] imm);
    return {opc, op, cnd, imm};
  endfunction

  // Behavioural model of one instruction.
  // kind: 0 = control flow resolved in decode, 1 = execute op, 2 = halt, 3 = illegal.
  task automatic model(input int cur_pc, input logic [15:0] ins, input logic n, input logic v,
                       input logic z, input int rv, output int kind, output int npc,
                       output bit lnk, output int seq);
    int imm, tgt;
    bit take;
    seq  = (cur_pc + 1) & AMASK;
    imm  = ins[7] ? int'(ins[7:0]) - 256 : int'(ins[7:0]);
    tgt  = (cur_pc + 1 + imm) & AMASK;
    take = 1'b0;
    lnk  = 1'b0;
    npc  = cur_pc;
    kind = 3;
    case (ins[15:13])
      3'd1: begin
        kind = 0;
        case (ins[10:8])
          3'd0: take = 1'b1;
          3'd1: take = z;
          3'd2: take = !z;
          3'd3: take = (n != v);
          3'd4: take = (n != v) || z;
          default: kind = 3;
        endcase
        if (kind == 0) npc = take ? tgt : seq;
      end
      3'd2: begin
        case (ins[12:11])
          2'd3: begin kind = 0; lnk = 1'b1; npc = tgt; end
          2'd0: begin kind = 0; npc = rv & AMASK; end
          2'd2: begin kind = 0; lnk = 1'b1; npc = rv & AMASK; end
          default: kind = 3;
        endcase
      end
      3'd3, 3'd4, 3'd5, 3'd6: kind = 1;
      3'd7: kind = 2;
      default: kind = 3;
    endcase
  endtask

  // Serve one fetch with `waits` wait states, then decode, then one more cycle.
  task automatic exec_one(input logic [15:0] instr, input int waits, input logic n,
                          input logic v, input logic z, input logic [ADDR_W-1:0] rv);
    fetch_bad = 0;
    N = n; V = v; Z = z; reg_value = rv;
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      mem_ready = (w == waits);
      mem_rdata = (w == waits) ? instr : 16'($urandom);
      #1;
      if (mem_cmd !== 2'b01 || mem_addr !== ADDR_W'(exp_pc)) fetch_bad++;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 16'($urandom);
    #1;
    o_ir = ir; o_ex_start = ex_start; o_link_we = link_we; o_link_pc = link_pc;
    o_dec_pc = pc; o_dec_cmd = mem_cmd;
    @(negedge clk);
    #1;
    o_post_pc = pc; o_post_cmd = mem_cmd; o_post_ex_start = ex_start;
    o_post_halted = halted; o_post_illegal = illegal;
  endtask

  // One data access from EXEC. It counts wrong command/address cycles and mem_ack pulses.
  task automatic do_dmem(input logic [ADDR_W-1:0] addr, input logic wr, input int waits,
                         output int bad, output int acks);
    bad = 0; acks = 0;
    @(negedge clk);
    mem_ready  = 1'b0;
    ex_mem_req = 1'b1; ex_wr = wr; ex_addr = addr;
    ex_done    = 1'($urandom_range(0, 1));   // must lose to the request
    #1;
    if (mem_ack !== 1'b0) bad++;
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      ex_mem_req = 1'b0; ex_done = 1'b0; ex_wr = ~wr; ex_addr = ADDR_W'($urandom);
      mem_ready  = (w == waits);
      #1;
      if (mem_cmd !== (wr ? 2'b10 : 2'b01) || mem_addr !== addr) bad++;
      if (mem_ack === 1'b1) acks++;
    end
  endtask

  task automatic finish_exec();
    @(negedge clk);
    mem_ready = 1'b0; ex_mem_req = 1'b0; ex_done = 1'b1;
    #1;
    o_fin_pre_pc = pc;
    @(negedge clk);
    ex_done = 1'b0;
    #1;
    o_fin_pc = pc; o_fin_cmd = mem_cmd;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0; ex_mem_req = 1'b0; ex_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_pc = RESET_PC;
    #1;
  endtask

  task automatic set_pc(input int target);
    exec_one(mk(3'd2, 2'd0, 3'($urandom), 8'($urandom)), 0, 1'b0, 1'b0, 1'b0, ADDR_W'(target));
    exp_pc = target & AMASK;
    tests_run++;
    if (o_post_pc !== ADDR_W'(target)) begin
      tests_failed++; $display("FAIL bx_set_pc: got %h expected %h", o_post_pc, ADDR_W'(target));
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({mem_cmd, ex_start, mem_ack, link_we, halted, illegal} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0", {mem_cmd, ex_start, mem_ack, link_we, halted, illegal});
    end
    tests_run++;
    if (pc !== ADDR_W'(RESET_PC) || ir !== '0) begin
      tests_failed++; $display("FAIL reset_pc_ir: got pc=%h ir=%h expected pc=%h ir=0", pc, ir, ADDR_W'(RESET_PC));
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (mem_cmd !== 2'b00) begin
      tests_failed++; $display("FAIL idle_cmd: got %b expected 00", mem_cmd);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (mem_cmd !== 2'b01 || mem_addr !== ADDR_W'(RESET_PC)) begin
      tests_failed++; $display("FAIL first_fetch: got cmd=%b addr=%h expected 01/%h", mem_cmd, mem_addr, ADDR_W'(RESET_PC));
    end
    exp_pc = RESET_PC;
  endtask

  task automatic test_mov();
    exec_one(16'hD105, 0, 1'b0, 1'b1, 1'b0, 9'h0AA);
    tests_run++;
    if (fetch_bad !== 0) begin tests_failed++; $display("FAIL mov_fetch: got %0d bad cycles expected 0", fetch_bad); end
    tests_run++;
    if (o_ir !== 16'hD105) begin tests_failed++; $display("FAIL mov_ir: got %h expected d105", o_ir); end
    tests_run++;
    if (o_ex_start !== 1'b1 || o_post_ex_start !== 1'b0) begin
      tests_failed++; $display("FAIL mov_ex_start: got %b%b expected 10", o_ex_start, o_post_ex_start);
    end
    finish_exec();
    tests_run++;
    if (o_fin_pre_pc !== 9'h000 || o_fin_pc !== 9'h001) begin
      tests_failed++; $display("FAIL mov_pc: got %h->%h expected 000->001", o_fin_pre_pc, o_fin_pc);
    end
    exp_pc = 1;
  endtask

  task automatic test_branch();
    set_pc(5);
    exec_one(mk(3'd1, 2'd0, 3'd1, 8'hFD), 1, 1'b0, 1'b0, 1'b1, 9'h000);
    tests_run++;
    if (o_post_pc !== 9'h003) begin tests_failed++; $display("FAIL beq_taken: got %h expected 003", o_post_pc); end
    exp_pc = 3;
    set_pc(5);
    exec_one(mk(3'd1, 2'd0, 3'd1, 8'hFD), 2, 1'b0, 1'b0, 1'b0, 9'h000);
    tests_run++;
    if (o_post_pc !== 9'h006) begin tests_failed++; $display("FAIL beq_not_taken: got %h expected 006", o_post_pc); end
    exp_pc = 6;
    set_pc(9'h1FF);
    exec_one(mk(3'd1, 2'd0, 3'd0, 8'h01), 0, 1'b0, 1'b0, 1'b0, 9'h000);
    tests_run++;
    if (o_post_pc !== 9'h001) begin tests_failed++; $display("FAIL b_wrap: got %h expected 001", o_post_pc); end
    exp_pc = 1;
  endtask

  task automatic test_bl();
    set_pc(4);
    exec_one(mk(3'd2, 2'd3, 3'd0, 8'h0A), 0, 1'b0, 1'b0, 1'b0, 9'h123);
    tests_run++;
    if (o_link_we !== 1'b1 || o_link_pc !== 9'h005) begin
      tests_failed++; $display("FAIL bl_link: got we=%b pc=%h expected 1/005", o_link_we, o_link_pc);
    end
    tests_run++;
    if (o_post_pc !== 9'h00F) begin tests_failed++; $display("FAIL bl_pc: got %h expected 00f", o_post_pc); end
    exp_pc = 15;
    exec_one(mk(3'd2, 2'd2, 3'd0, 8'h00), 1, 1'b0, 1'b0, 1'b0, 9'h0C3);
    tests_run++;
    if (o_link_we !== 1'b1 || o_link_pc !== 9'h010 || o_post_pc !== 9'h0C3) begin
      tests_failed++; $display("FAIL blx: got we=%b link=%h pc=%h expected 1/010/0c3", o_link_we, o_link_pc, o_post_pc);
    end
    exp_pc = 9'h0C3;
  endtask

  task automatic test_ldr_str();
    int bad, acks;
    exec_one(mk(3'd4, 2'd0, 3'd2, 8'h40), 0, 1'b0, 1'b0, 1'b0, 9'h000);
    do_dmem(9'h140, 1'b0, 3, bad, acks);
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL ldr_hold: got %0d bad cycles expected 0", bad); end
    tests_run++;
    if (acks !== 1) begin tests_failed++; $display("FAIL ldr_ack: got %0d pulses expected 1", acks); end
    do_dmem(9'h0F0, 1'b1, 0, bad, acks);
    tests_run++;
    if (bad !== 0 || acks !== 1) begin
      tests_failed++; $display("FAIL str_access: got bad=%0d acks=%0d expected 0/1", bad, acks);
    end
    finish_exec();
    tests_run++;
    if (o_fin_pc !== ADDR_W'(exp_pc + 1) || o_fin_cmd !== 2'b01) begin
      tests_failed++; $display("FAIL ldr_done: got pc=%h cmd=%b expected %h/01", o_fin_pc, o_fin_cmd, ADDR_W'(exp_pc + 1));
    end
    exp_pc = (exp_pc + 1) & AMASK;
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [15:0] ins;
      logic n, v, z;
      logic [ADDR_W-1:0] rv;
      int kind, npc, seq, cat, bad, acks, start_pc;
      bit lnk;
      cat = $urandom_range(0, 2);
      if (cat == 0)      ins = mk(3'd1, 2'($urandom), 3'($urandom_range(0, 4)), 8'($urandom));
      else if (cat == 1) ins = mk(3'd2, (($urandom_range(0, 2) == 0) ? 2'd0 : (($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3)),
                                  3'($urandom), 8'($urandom));
      else               ins = mk(3'($urandom_range(3, 6)), 2'($urandom), 3'($urandom), 8'($urandom));
      n = 1'($urandom); v = 1'($urandom); z = 1'($urandom); rv = ADDR_W'($urandom);
      start_pc = exp_pc;
      model(start_pc, ins, n, v, z, int'(rv), kind, npc, lnk, seq);
      exec_one(ins, $urandom_range(0, 3), n, v, z, rv);
      tests_run++;
      if (fetch_bad !== 0 || o_ir !== ins || o_dec_cmd !== 2'b00) begin
        tests_failed++;
        $display("FAIL rnd_fetch: got bad=%0d ir=%h cmd=%b expected 0/%h/00", fetch_bad, o_ir, o_dec_cmd, ins);
      end
      if (kind == 0) begin
        tests_run++;
        if (o_post_pc !== ADDR_W'(npc) || o_link_we !== lnk || o_ex_start !== 1'b0) begin
          tests_failed++;
          $display("FAIL rnd_flow: got pc=%h we=%b xs=%b expected %h/%b/0", o_post_pc, o_link_we, o_ex_start, ADDR_W'(npc), lnk);
        end
        if (lnk) begin
          tests_run++;
          if (o_link_pc !== ADDR_W'(seq)) begin
            tests_failed++; $display("FAIL rnd_link_pc: got %h expected %h", o_link_pc, ADDR_W'(seq));
          end
        end
        exp_pc = npc;
      end else begin
        tests_run++;
        if (o_ex_start !== 1'b1 || o_post_ex_start !== 1'b0 || o_post_pc !== ADDR_W'(start_pc)) begin
          tests_failed++;
          $display("FAIL rnd_exec_start: got xs=%b%b pc=%h expected 10/%h", o_ex_start, o_post_ex_start, o_post_pc, ADDR_W'(start_pc));
        end
        for (int k = 0; k < $urandom_range(0, 2); k++) begin
          logic [ADDR_W-1:0] a;
          logic wr;
          a = ADDR_W'($urandom); wr = 1'($urandom);
          do_dmem(a, wr, $urandom_range(0, 3), bad, acks);
          tests_run++;
          if (bad !== 0 || acks !== 1) begin
            tests_failed++; $display("FAIL rnd_dmem: got bad=%0d acks=%0d expected 0/1", bad, acks);
          end
        end
        finish_exec();
        tests_run++;
        if (o_fin_pre_pc !== ADDR_W'(start_pc) || o_fin_pc !== ADDR_W'(seq)) begin
          tests_failed++;
          $display("FAIL rnd_exec_done: got %h->%h expected %h->%h", o_fin_pre_pc, o_fin_pc, ADDR_W'(start_pc), ADDR_W'(seq));
        end
        exp_pc = seq;
      end
      $display("[TB] txn %0d pc=%03h instr=%04h kind=%0d next_pc=%03h", t, start_pc, ins, kind, exp_pc);
    end
  endtask

  task automatic test_reset_mid_fetch();
    set_pc(9'h0AB);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    tests_run++;
    if (mem_cmd !== 2'b01 || mem_addr !== 9'h0AB) begin
      tests_failed++; $display("FAIL wait_state: got cmd=%b addr=%h expected 01/0ab", mem_cmd, mem_addr);
    end
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 16'hE000; reset = 1'b0;
    #1;
    tests_run++;
    if (mem_cmd !== 2'b00 || pc !== ADDR_W'(RESET_PC) || ir !== '0) begin
      tests_failed++; $display("FAIL async_reset: got cmd=%b pc=%h ir=%h expected 00/%h/0", mem_cmd, pc, ir, ADDR_W'(RESET_PC));
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (ir !== '0 || pc !== ADDR_W'(RESET_PC) || halted !== 1'b0) begin
      tests_failed++; $display("FAIL reset_abort: got ir=%h pc=%h halted=%b expected 0/%h/0", ir, pc, halted, ADDR_W'(RESET_PC));
    end
    mem_ready = 1'b0;
    reset = 1'b1;
    exp_pc = RESET_PC;
  endtask

  task automatic test_halt();
    int bad;
    bad = 0;
    exec_one(16'hE000, 1, 1'b0, 1'b0, 1'b0, 9'h000);
    tests_run++;
    if (o_post_halted !== 1'b1 || o_post_cmd !== 2'b00 || o_post_illegal !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_enter: got h=%b cmd=%b ill=%b expected 1/00/0", o_post_halted, o_post_cmd, o_post_illegal);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom); ex_done = 1'($urandom); ex_mem_req = 1'($urandom);
      #1;
      if (halted !== 1'b1 || mem_cmd !== 2'b00 || pc !== ADDR_W'(exp_pc) || mem_ack !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL halt_stay: got %0d bad cycles expected 0", bad); end
    apply_reset();
    tests_run++;
    if (halted !== 1'b0 || mem_cmd !== 2'b00) begin
      tests_failed++; $display("FAIL halt_reset: got h=%b cmd=%b expected 0/00", halted, mem_cmd);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] enc [4];
    enc[0] = 16'h0000;
    enc[1] = mk(3'd1, 2'd0, 3'd5, 8'h12);
    enc[2] = mk(3'd1, 2'd1, 3'd7, 8'hF0);
    enc[3] = mk(3'd2, 2'd1, 3'd0, 8'h05);
    for (int k = 0; k < 4; k++) begin
      apply_reset();
      exec_one(enc[k], k, 1'b0, 1'b0, 1'b1, 9'h055);
      tests_run++;
      if (o_post_illegal !== 1'b1 || o_post_halted !== 1'b1 || o_post_pc !== ADDR_W'(RESET_PC)) begin
        tests_failed++;
        $display("FAIL illegal_%0d: got ill=%b h=%b pc=%h expected 1/1/%h", k, o_post_illegal, o_post_halted, o_post_pc, ADDR_W'(RESET_PC));
      end
      tests_run++;
      if (o_ex_start !== 1'b0 || o_link_we !== 1'b0) begin
        tests_failed++; $display("FAIL illegal_side_%0d: got xs=%b we=%b expected 0/0", k, o_ex_start, o_link_we);
      end
    end
    apply_reset();
    tests_run++;
    if (illegal !== 1'b0) begin tests_failed++; $display("FAIL illegal_clear: got %b expected 0", illegal); end
  endtask

  initial begin
    reset = 1'b0; mem_rdata = '0; mem_ready = 1'b0; N = 1'b0; V = 1'b0; Z = 1'b0;
    reg_value = '0; ex_mem_req = 1'b0; ex_wr = 1'b0; ex_addr = '0; ex_done = 1'b0;
    exp_pc = RESET_PC;
    test_reset();
    test_mov();
    test_branch();
    test_bl();
    test_ldr_str();
    test_random();
    test_reset_mid_fetch();
    test_halt();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
